// File: rtl/fixed_to_dec_pkg.sv
// rtl/fixed_to_dec_pkg.sv - shared types and constants for the fixed-point to decimal converter
// FIXED_TO_DEC_ASCII_EN selects 8-bit ASCII digits instead of 4-bit binary digits.
package fixed_to_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_EMIT,
    ST_DONE
  } state_t;

  typedef logic [15:0] word_t;

`ifdef FIXED_TO_DEC_ASCII_EN
  localparam int DIGIT_W = 8;
`else
  localparam int DIGIT_W = 4;
`endif

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_DOT  = 8'h2E;

endpackage

// File: rtl/mul10_word.sv
// rtl/mul10_word.sv - one word slice of a multiply-by-10 with carry in/out
module mul10_word (
  input  logic [15:0] w,
  input  logic [3:0]  c,
  output logic [15:0] w_next,
  output logic [3:0]  c_next
);

  // Worst case 0xFFFF*10+9 = 0x9FFFF, so the carry-out never exceeds 9.
  logic [19:0] prod;

  assign prod             = (20'(w) * 20'd10) + 20'(c);
  assign {c_next, w_next} = prod;

endmodule

// File: rtl/fixed_to_dec.sv
// rtl/fixed_to_dec.sv - latches a multi-word fixed-point value and streams its fractional decimal digits
// FIXED_TO_DEC_ASCII_EN: ASCII digits with a leading '.' beat; undefined gives 4-bit binary digits.
module fixed_to_dec
  import fixed_to_dec_pkg::*;
#(
  parameter int WORDS     = 32,
  parameter int INT_WORDS = 1,
  parameter int DIGITS    = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORDS-1:0][15:0]    fixed_data,
  output logic [16*INT_WORDS-1:0]   int_part,
  output logic [DIGIT_W-1:0]        digit,
  output logic                      digit_valid,
  input  logic                      digit_ready,
  output logic                      digit_last,
  output logic                      busy,
  output logic                      done
);

  localparam int FRAC_WORDS = WORDS - INT_WORDS;
  localparam int IDX_W      = (FRAC_WORDS > 1) ? $clog2(FRAC_WORDS) : 1;
  localparam int CNT_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAC_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t           state, state_nxt;
  word_t            frac_buf [FRAC_WORDS];
  logic [IDX_W-1:0] idx;
  logic [3:0]       carry;
  logic [CNT_W-1:0] cnt;
  word_t            w_new;
  logic [3:0]       c_new;
  logic             fire;
  logic             last_word;
  logic             last_digit;
`ifdef FIXED_TO_DEC_ASCII_EN
  logic             dot_beat;
`endif

  assign fire       = (state == ST_EMIT) && digit_ready;
  assign last_word  = (idx == LAST_IDX);
  assign last_digit = (cnt == LAST_CNT);

  // Single multiplier slice walks the buffer LSW first so the carry ripples upward.
  mul10_word u_mul10 (
    .w      (frac_buf[idx]),
    .c      (carry),
    .w_next (w_new),
    .c_next (c_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef FIXED_TO_DEC_ASCII_EN
          state_nxt = ST_EMIT;
`else
          state_nxt = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        if (last_word) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (fire) begin
`ifdef FIXED_TO_DEC_ASCII_EN
          if (!dot_beat && last_digit) state_nxt = ST_DONE;
          else                         state_nxt = ST_MUL;
`else
          if (last_digit) state_nxt = ST_DONE;
          else            state_nxt = ST_MUL;
`endif
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    digit_valid = (state == ST_EMIT);
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAC_WORDS; i++) frac_buf[i] <= '0;
      int_part   <= '0;
      digit      <= '0;
      digit_last <= 1'b0;
      idx        <= '0;
      carry      <= '0;
      cnt        <= '0;
`ifdef FIXED_TO_DEC_ASCII_EN
      dot_beat   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < FRAC_WORDS; i++) frac_buf[i] <= fixed_data[i];
            int_part <= fixed_data[WORDS-1:FRAC_WORDS];
            idx      <= '0;
            carry    <= '0;
            cnt      <= '0;
`ifdef FIXED_TO_DEC_ASCII_EN
            digit      <= ASCII_DOT;
            digit_last <= 1'b0;
            dot_beat   <= 1'b1;
`endif
          end
        end
        ST_MUL: begin
          frac_buf[idx] <= w_new;
          if (last_word) begin
`ifdef FIXED_TO_DEC_ASCII_EN
            digit <= ASCII_ZERO + {4'b0000, c_new};
`else
            digit <= c_new;
`endif
            digit_last <= last_digit;
            carry      <= '0;
            idx        <= '0;
          end else begin
            carry <= c_new;
            idx   <= idx + 1'b1;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            idx <= '0;
`ifdef FIXED_TO_DEC_ASCII_EN
            dot_beat <= 1'b0;
            if (!dot_beat && !last_digit) cnt <= cnt + 1'b1;
`else
            if (!last_digit) cnt <= cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_dec.sv
// tb/tb_fixed_to_dec.sv - randomized self-checking bench for fixed_to_dec against a big-number reference
module tb_fixed_to_dec;

  localparam int WORDS     = 8;
  localparam int INT_WORDS = 1;
  localparam int DIGITS    = 10;
  localparam int F         = WORDS - INT_WORDS;
`ifdef FIXED_TO_DEC_ASCII_EN
  localparam int ASC = 1;
  localparam int DW  = 8;
`else
  localparam int ASC = 0;
  localparam int DW  = 4;
`endif
  localparam int BEATS      = DIGITS + ASC;
  localparam int EXP_DONE_K = DIGITS * (F + 1) + 2 * ASC;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [WORDS-1:0][15:0]  fixed_data;
  logic [16*INT_WORDS-1:0] int_part;
  logic [DW-1:0]           digit;
  logic                    digit_valid;
  logic                    digit_ready;
  logic                    digit_last;
  logic                    busy;
  logic                    done;

  int checks = 0;
  int errors = 0;
  int exp_d [DIGITS];
  int got_d [DIGITS];

  always #5 clk = ~clk;

  fixed_to_dec #(.WORDS(WORDS), .INT_WORDS(INT_WORDS), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fixed_data  (fixed_data),
    .int_part    (int_part),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_last  (digit_last),
    .busy        (busy),
    .done        (done)
  );

  // Reference: treat the fraction as one 112-bit number; each digit is floor(frac*10 / 2^112).
  task automatic model_digits(input logic [111:0] frac);
    logic [115:0] p;
    logic [111:0] f;
    f = frac;
    for (int i = 0; i < DIGITS; i++) begin
      p = 116'(f) * 116'd10;
      exp_d[i] = int'(p[115:112]);
      f = p[111:0];
    end
  endtask

  task automatic start_conv(input logic [127:0] v);
    fixed_data = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fixed_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic run_conv(input logic [127:0] v, input int stall_beat, input bit rand_ready,
                          input int pulse_k, input bit check_time, input string name);
    int k, beat, stall_left, di;
    bit got_done, busy_ok;
    logic [DW-1:0] held, exp_dig;
    logic exp_last;
    k = 0; beat = 0; stall_left = 5; got_done = 0; busy_ok = 1; held = '0;
    model_digits(v[111:0]);
    start_conv(v);
    checks++;
    if (int_part !== v[127:112])
      $display("FAIL %s int_part got %h want %h", name, int_part, v[127:112]);
    if (int_part !== v[127:112]) errors++;
    while (!got_done && k < 4000) begin
      if (done === 1'b1) begin
        got_done = 1;
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_at_done got %b want 1", name, busy);
        end
        if (check_time) begin
          checks++;
          if (k != EXP_DONE_K) begin
            errors++; $display("FAIL %s done_latency got %0d want %0d", name, k, EXP_DONE_K);
          end
        end
      end else begin
        if (busy !== 1'b1) busy_ok = 0;
        start = (k == pulse_k);
        if (start) fixed_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (digit_valid === 1'b1) begin
          if (beat == stall_beat && stall_left > 0) begin
            digit_ready = 1'b0;
            if (stall_left < 5) begin
              checks++;
              if (digit !== held) begin
                errors++; $display("FAIL %s stall_hold got %h want %h", name, digit, held);
              end
            end
            held = digit;
            stall_left--;
          end else begin
            digit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (digit_ready) begin
              checks++;
              if (beat >= BEATS) begin
                errors++; $display("FAIL %s extra_beat got %0d want %0d", name, beat + 1, BEATS);
              end else begin
                if (ASC == 1 && beat == 0) begin
                  exp_dig = DW'(8'h2E);
                  exp_last = 1'b0;
                end else begin
                  di = beat - ASC;
                  exp_dig = DW'(ASC * 48 + exp_d[di]);
                  exp_last = (di == DIGITS - 1);
                  got_d[di] = int'(digit) - ASC * 48;
                end
                if ({digit, digit_last} !== {exp_dig, exp_last}) begin
                  errors++;
                  $display("FAIL %s beat%0d got digit %h last %b want digit %h last %b",
                           name, beat, digit, digit_last, exp_dig, exp_last);
                end
              end
              beat++;
            end
          end
        end else begin
          if (beat == stall_beat && stall_left > 0 && stall_left < 5) begin
            checks++; errors++;
            $display("FAIL %s stall_valid got 0 want 1", name);
            stall_left = 0;
          end
          digit_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    digit_ready = 1'b0;
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL %s done_timeout got none want pulse", name);
    end
    checks++;
    if (beat != BEATS) begin
      errors++; $display("FAIL %s beat_count got %0d want %0d", name, beat, BEATS);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s busy_drop got 0 want 1", name);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL %s after_done busy/done got %b want 00", name, {busy, done});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({int_part, digit, digit_valid, digit_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got int %h digit %h v %b l %b busy %b done %b want all 0",
               int_part, digit, digit_valid, digit_last, busy, done);
    end
  endtask

  task automatic test_half();
    int want [4];
    want = '{5, 0, 0, 0};
    run_conv({16'h0002, 16'h8000, 96'h0}, -1, 1'b0, -1, 1'b1, "half");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_d[i] != want[i]) begin
        errors++; $display("FAIL half_digit%0d got %0d want %0d", i, got_d[i], want[i]);
      end
    end
  endtask

  task automatic test_patterns();
    run_conv({16'h0001, {7{16'h5555}}}, -1, 1'b0, -1, 1'b1, "thirds");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_d[i] != 3) begin
        errors++; $display("FAIL thirds_digit%0d got %0d want 3", i, got_d[i]);
      end
    end
    run_conv({16'hFFFF, {7{16'hFFFF}}}, -1, 1'b0, -1, 1'b1, "nines");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_d[i] != 9) begin
        errors++; $display("FAIL nines_digit%0d got %0d want 9", i, got_d[i]);
      end
    end
  endtask

  task automatic test_e_backpressure();
    int e_ref [10];
    e_ref = '{7, 1, 8, 2, 8, 1, 8, 2, 8, 4};
    run_conv({16'h0002, 16'hB7E1, 16'h5162, 16'h8AED, 16'h2A6A, 16'hBF71, 16'h5880, 16'h9CF4},
             1 + ASC, 1'b0, 20, 1'b0, "e_const");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_d[i] != e_ref[i]) begin
        errors++; $display("FAIL e_digit%0d got %0d want %0d", i, got_d[i], e_ref[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      run_conv({$urandom(), $urandom(), $urandom(), $urandom()}, -1, 1'b1, 30 + n, 1'b0, "random");
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 0;
    digit_ready = 1'b1;
    start_conv({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (2 * (F + 1) + 3 + 2 * ASC) @(negedge clk);
    checks++;
    if ({busy, digit_valid} !== 2'b10) begin
      errors++; $display("FAIL mid_in_mul busy/valid got %b want 10", {busy, digit_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({int_part, digit, digit_valid, digit_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL mid_reset got int %h digit %h v %b l %b busy %b done %b want all 0",
               int_part, digit, digit_valid, digit_last, busy, done);
    end
    rst = 1'b0;
    repeat (200) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL mid_no_done got activity want idle");
    end
    digit_ready = 1'b0;
    run_conv({$urandom(), $urandom(), $urandom(), $urandom()}, -1, 1'b0, -1, 1'b1, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    digit_ready = 1'b0;
    fixed_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_half();
    test_patterns();
    test_e_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
